// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
//   Shared constants for the I2C master and its AXI-Stream front end.
//   AXIS_DATA_WIDTH  width of the command/data byte stream
//   AXIS_WORD_WIDTH  stored word width: {tlast, tdata}
//   I2C_FIFO_DEPTH   default depth of the upstream packet FIFO
//   ptr_width()      pointer/count width for a FIFO of a given depth
//                    (address bits plus one wrap bit)
// -----------------------------------------------------------------------------
package i2c_pkg;

  localparam int AXIS_DATA_WIDTH = 8;
  localparam int AXIS_WORD_WIDTH = AXIS_DATA_WIDTH + 1;
  localparam int I2C_FIFO_DEPTH  = 16;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// -----------------------------------------------------------------------------
// axis_fifo_ram
//   Storage array for axis_pkt_fifo: synchronous write, asynchronous read,
//   so the FIFO head is available combinationally (first-word fall-through).
//   Contents are deliberately not reset.
// Ports
//   clk_i    clock, rising edge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write word {tlast, tdata}
//   raddr_i  read address
//   rdata_o  read word, combinational from raddr_i
// -----------------------------------------------------------------------------
module axis_fifo_ram
  import i2c_pkg::*;
#(
  parameter int  DEPTH = I2C_FIFO_DEPTH,
  parameter int  WIDTH = AXIS_WORD_WIDTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// axis_pkt_fifo
//   Synchronous AXI-Stream FIFO in front of the I2C master's AXIS slave port.
//   Each word is stored with its tlast. With PACKET_MODE=1 the output is held
//   back until a complete packet (a word with tlast) is stored, so an I2C
//   transaction that has started never runs dry. A packet longer than DEPTH
//   cannot be held whole; when the FIFO fills without any tlast stored, the
//   FSM switches to RELEASE and streams until that packet's tlast is popped.
//   With PACKET_MODE=0 it is a plain first-word fall-through FIFO.
//
// Handshake: a beat transfers on a rising edge where tvalid & tready are both
//   high; tvalid never waits on tready, and once tvalid is high for a word it
//   stays high with tdata/tlast stable until that word transfers. The write
//   side is only ever backpressured (tready = !full), nothing is dropped.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset (clears pointers, counters, FSM)
//   s_axis_tdata   write data
//   s_axis_tvalid  write valid
//   s_axis_tlast   write end-of-packet
//   s_axis_tready  write ready (low while full or in reset)
//   m_axis_tdata   read data (head of FIFO)
//   m_axis_tvalid  read valid (low in reset)
//   m_axis_tlast   read end-of-packet
//   m_axis_tready  read ready
//   count_o        words stored, 0..DEPTH
//   pkt_cnt_o      complete packets stored (stored words with tlast=1)
//   full_o         count_o == DEPTH
//   empty_o        count_o == 0
//   state_o        FSM state: 0 = HOLD, 1 = RELEASE
// -----------------------------------------------------------------------------
module axis_pkt_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH       = I2C_FIFO_DEPTH,
  parameter bit PACKET_MODE = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [ptr_width(DEPTH)-1:0]   count_o,
  output logic [ptr_width(DEPTH)-1:0]   pkt_cnt_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  typedef enum logic {
    ST_HOLD    = 1'b0,
    ST_RELEASE = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q, pkt_cnt_q;
  logic                       push, pop, push_last, pop_last;
  logic [AXIS_WORD_WIDTH-1:0] wr_word, rd_word;

  // ---------------------------------------------------------------------------
  // Status. The pointer MSB is a wrap bit: equal addresses with different wrap
  // bits means the writer is a full lap ahead.
  // ---------------------------------------------------------------------------
  assign full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign pkt_cnt_o = pkt_cnt_q;

  // tready depends only on stored state, never on m_axis_tready: a full FIFO
  // refuses a write even in a cycle where it is also being read.
  assign s_axis_tready = !rst_i && !full_o;

  assign push      = s_axis_tvalid && s_axis_tready;
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign push_last = push && s_axis_tlast;
  assign pop_last  = pop && m_axis_tlast;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  assign wr_word = {s_axis_tlast, s_axis_tdata};

  axis_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (AXIS_WORD_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_word),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_word)
  );

  assign m_axis_tdata = rd_word[AXIS_DATA_WIDTH-1:0];
  assign m_axis_tlast = rd_word[AXIS_DATA_WIDTH];

  // ---------------------------------------------------------------------------
  // Pointers and packet counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_cnt_q <= '0;
    end else begin
      case ({push_last, pop_last})
        2'b10:   pkt_cnt_q <= pkt_cnt_q + PW'(1);
        2'b01:   pkt_cnt_q <= pkt_cnt_q - PW'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // HOLD/RELEASE FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // Full with no tlast stored: the packet cannot complete inside the
      // FIFO, so start streaming it out instead of deadlocking.
      ST_HOLD:    if (full_o && (pkt_cnt_q == '0)) state_d = ST_RELEASE;
      ST_RELEASE: if (pop_last)                    state_d = ST_HOLD;
      default:    state_d = ST_HOLD;
    endcase
  end

  // tvalid is built from registered state only, so there is no combinational
  // path from the write side to the read side. In HOLD, tvalid can only drop
  // when a tlast word is popped, which keeps a presented word valid until it
  // transfers.
  always_comb begin
    m_axis_tvalid = 1'b0;
    state_o       = (state_q == ST_RELEASE);
    if (!rst_i && !empty_o) begin
      if (!PACKET_MODE) begin
        m_axis_tvalid = 1'b1;
      end else begin
        m_axis_tvalid = (pkt_cnt_q != '0) || (state_q == ST_RELEASE);
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_fifo
//   Two instances share clock and reset: u_dut_pkt (PACKET_MODE=1) and
//   u_dut_ff (PACKET_MODE=0). Index 0 = pkt, index 1 = ff in tasks and logs.
//   The reference model is the queue of accepted words per instance; status
//   and tvalid are derived from that queue every cycle.
// -----------------------------------------------------------------------------
module tb_axis_pkt_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic [W-1:0]  p_s_tdata, p_m_tdata, f_s_tdata, f_m_tdata;
  logic          p_s_tvalid, p_s_tlast, p_s_tready, p_m_tvalid, p_m_tlast, p_m_tready;
  logic          f_s_tvalid, f_s_tlast, f_s_tready, f_m_tvalid, f_m_tlast, f_m_tready;
  logic [CW-1:0] p_count, p_pkt_cnt, f_count, f_pkt_cnt;
  logic          p_full, p_empty, p_state, f_full, f_empty, f_state;

  axis_pkt_fifo #(.DEPTH(DEPTH), .PACKET_MODE(1'b1)) u_dut_pkt (
    .clk_i(clk), .rst_i(rst),
    .s_axis_tdata(p_s_tdata), .s_axis_tvalid(p_s_tvalid), .s_axis_tlast(p_s_tlast),
    .s_axis_tready(p_s_tready),
    .m_axis_tdata(p_m_tdata), .m_axis_tvalid(p_m_tvalid), .m_axis_tlast(p_m_tlast),
    .m_axis_tready(p_m_tready),
    .count_o(p_count), .pkt_cnt_o(p_pkt_cnt), .full_o(p_full), .empty_o(p_empty),
    .state_o(p_state)
  );

  axis_pkt_fifo #(.DEPTH(DEPTH), .PACKET_MODE(1'b0)) u_dut_ff (
    .clk_i(clk), .rst_i(rst),
    .s_axis_tdata(f_s_tdata), .s_axis_tvalid(f_s_tvalid), .s_axis_tlast(f_s_tlast),
    .s_axis_tready(f_s_tready),
    .m_axis_tdata(f_m_tdata), .m_axis_tvalid(f_m_tvalid), .m_axis_tlast(f_m_tlast),
    .m_axis_tready(f_m_tready),
    .count_o(f_count), .pkt_cnt_o(f_pkt_cnt), .full_o(f_full), .empty_o(f_empty),
    .state_o(f_state)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  bit done_p, done_f;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%s] t=%0t got=%0h expected=%0h",
                  name, (idx == 0) ? "pkt" : "ff", $time, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboards: input monitor captures accepted beats into exp_q, output
  // monitor checks status every cycle and pops/compares on each read beat.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_sb
    localparam bit PM = (g == 0);

    logic [W-1:0]  s_tdata, m_tdata;
    logic          s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_tready;
    logic          full, empty, state;
    logic [CW-1:0] count, pkt_cnt;

    assign s_tdata  = (g == 0) ? p_s_tdata  : f_s_tdata;
    assign s_tvalid = (g == 0) ? p_s_tvalid : f_s_tvalid;
    assign s_tlast  = (g == 0) ? p_s_tlast  : f_s_tlast;
    assign s_tready = (g == 0) ? p_s_tready : f_s_tready;
    assign m_tdata  = (g == 0) ? p_m_tdata  : f_m_tdata;
    assign m_tvalid = (g == 0) ? p_m_tvalid : f_m_tvalid;
    assign m_tlast  = (g == 0) ? p_m_tlast  : f_m_tlast;
    assign m_tready = (g == 0) ? p_m_tready : f_m_tready;
    assign full     = (g == 0) ? p_full     : f_full;
    assign empty    = (g == 0) ? p_empty    : f_empty;
    assign state    = (g == 0) ? p_state    : f_state;
    assign count    = (g == 0) ? p_count    : f_count;
    assign pkt_cnt  = (g == 0) ? p_pkt_cnt  : f_pkt_cnt;

    logic [W:0] exp_q[$];
    logic       rel    = 1'b0;   // a too-long packet is being streamed out
    logic       hold_v = 1'b0;
    logic [W:0] hold_w;
    logic       in_fire;
    logic [W:0] in_word;

    always begin : in_mon
      @(negedge clk);
      in_fire = !rst && s_tvalid && s_tready;
      in_word = {s_tlast, s_tdata};
      @(posedge clk);
      if (in_fire) exp_q.push_back(in_word);
    end

    always @(negedge clk) begin : out_mon
      int         n, nl;
      logic       pop, exp_v;
      logic [W:0] w;
      if (rst) begin
        chk("rst_s_tready", g, 32'(s_tready), 32'(0));
        chk("rst_m_tvalid", g, 32'(m_tvalid), 32'(0));
        exp_q.delete();
        rel    = 1'b0;
        hold_v = 1'b0;
      end else begin
        n  = exp_q.size();
        nl = 0;
        foreach (exp_q[i]) if (exp_q[i][W]) nl++;
        chk("count",   g, 32'(count),    32'(n));
        chk("pkt_cnt", g, 32'(pkt_cnt),  32'(nl));
        chk("full",    g, 32'(full),     32'(n == DEPTH));
        chk("empty",   g, 32'(empty),    32'(n == 0));
        chk("s_tready", g, 32'(s_tready), 32'(n != DEPTH));
        exp_v = (n > 0) && (!PM || (nl > 0) || rel);
        chk("m_tvalid", g, 32'(m_tvalid), 32'(exp_v));
        if (PM) chk("fsm_state", g, 32'(state), 32'(rel));
        if (hold_v) begin
          chk("hold_tvalid", g, 32'(m_tvalid), 32'(1));
          chk("hold_word",   g, 32'({m_tlast, m_tdata}), 32'(hold_w));
        end
        pop = m_tvalid && m_tready;
        if (pop && n > 0) begin
          w = exp_q.pop_front();
          chk("pop_word", g, 32'({m_tlast, m_tdata}), 32'(w));
        end
        if (PM) begin
          if (rel && pop && m_tlast)                rel = 1'b0;
          else if (!rel && n == DEPTH && nl == 0)   rel = 1'b1;
        end
        hold_v = m_tvalid && !m_tready;
        hold_w = {m_tlast, m_tdata};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_m_tready(input int idx, input logic v);
    if (idx == 0) p_m_tready = v;
    else          f_m_tready = v;
  endtask

  task automatic send(input int idx, input logic [W-1:0] d, input logic l);
    int   budget;
    logic acc;
    budget = 400;
    acc    = 1'b0;
    if (idx == 0) begin p_s_tvalid = 1'b1; p_s_tdata = d; p_s_tlast = l; end
    else          begin f_s_tvalid = 1'b1; f_s_tdata = d; f_s_tlast = l; end
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = (idx == 0) ? p_s_tready : f_s_tready;
      @(posedge clk);
      #1;
      budget--;
    end
    if (!acc) chk("push_timeout", idx, 32'(acc), 32'(1));
    if (idx == 0) p_s_tvalid = 1'b0;
    else          f_s_tvalid = 1'b0;
  endtask

  task automatic drain(input int idx);
    int budget;
    budget = 200;
    set_m_tready(idx, 1'b1);
    while (!((idx == 0) ? p_empty : f_empty) && budget > 0) begin
      tick(1);
      budget--;
    end
    if (budget == 0) chk("drain_timeout", idx, 32'((idx == 0) ? p_empty : f_empty), 32'(1));
    set_m_tready(idx, 1'b0);
  endtask

  task automatic produce(input int idx, input int nwords, input int maxlen);
    int left;
    left = $urandom_range(1, maxlen);
    for (int i = 0; i < nwords; i++) begin
      tick($urandom_range(0, 2));
      left--;
      send(idx, 8'($urandom), (left == 0) || (i == nwords - 1));
      if (left == 0) left = $urandom_range(1, maxlen);
    end
    if (idx == 0) done_p = 1'b1;
    else          done_f = 1'b1;
  endtask

  task automatic consume(input int idx, input int pct);
    int budget;
    budget = 4000;
    while (budget > 0) begin
      set_m_tready(idx, int'($urandom_range(0, 99)) < pct);
      tick(1);
      budget--;
      if (((idx == 0) ? done_p : done_f) && ((idx == 0) ? p_empty : f_empty)) break;
    end
    if (budget == 0) chk("consume_timeout", idx, 32'((idx == 0) ? p_empty : f_empty), 32'(1));
    set_m_tready(idx, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    p_s_tdata = '0; p_s_tvalid = 1'b0; p_s_tlast = 1'b0; p_m_tready = 1'b0;
    f_s_tdata = '0; f_s_tvalid = 1'b0; f_s_tlast = 1'b0; f_m_tready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);

    // Packet release timing: nothing visible until the tlast word is stored.
    p_m_tready = 1'b1;
    send(0, 8'hA0, 1'b0);
    send(0, 8'hA1, 1'b0);
    send(0, 8'hA2, 1'b1);
    tick(5);

    // Fill with a tlast-free packet: full, RELEASE, then a 17th word once room.
    p_m_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(0, 8'(i), 1'b0);
    tick(2);
    fork
      send(0, 8'(DEPTH), 1'b1);
      begin tick(3); p_m_tready = 1'b1; end
    join
    drain(0);

    // Simultaneous push(tlast)+pop(tlast) at count 5.
    p_m_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(0, 8'(8'h50 + i), 1'b1);
    p_m_tready = 1'b1;
    send(0, 8'h55, 1'b1);
    p_m_tready = 1'b0;
    tick(2);
    drain(0);

    // Full with a pop in the same cycle: the write is refused that cycle.
    for (int i = 0; i < DEPTH; i++) send(0, 8'(8'h60 + i), (i % 4) == 3);
    p_m_tready = 1'b1;
    send(0, 8'h7E, 1'b1);
    p_m_tready = 1'b0;
    tick(1);
    drain(0);

    // Backpressure: stable head word while tready is low for 10 cycles.
    send(0, 8'hC0, 1'b0);
    send(0, 8'hC1, 1'b0);
    send(0, 8'hC2, 1'b1);
    tick(10);
    drain(0);

    // Random streaming with gaps; pointers wrap many times.
    done_p = 1'b0;
    done_f = 1'b0;
    fork
      produce(1, 100, 8);
      consume(1, 60);
      produce(0, 80, 24);
      consume(0, 60);
    join

    // Reset in the middle of traffic on both instances.
    done_p = 1'b0;
    done_f = 1'b0;
    fork
      produce(0, 40, 6);
      consume(0, 40);
      produce(1, 40, 6);
      consume(1, 40);
      begin tick(25); rst = 1'b1; tick(2); rst = 1'b0; end
    join
    drain(0);
    drain(1);
    tick(3);

    chk("leftover", 0, 32'(g_sb[0].exp_q.size()), 32'(0));
    chk("leftover", 1, 32'(g_sb[1].exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
